// File: rtl/cache_pkg.sv
// Shared state encoding and address-split width helpers for the cache controller slice.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } state_t;

  // NUM_SETS is expected to be a power of two, at least 2.
  function automatic int unsigned set_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_size, input int unsigned num_sets);
    return addr_size - 2 - set_bits(num_sets);
  endfunction

  function automatic int unsigned way_bits(input int unsigned num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU-side request/response bus: master is the requester, slave is the cache controller.
interface cache_controller_if #(
  parameter int unsigned ADDR_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/cache_replacement.sv
// Per-set round-robin victim pointers; the lowest invalid way always wins over the pointer.
module cache_replacement
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned NUM_WAYS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [set_bits(NUM_SETS)-1:0] set,
  input  logic [NUM_WAYS-1:0]           valid_flags,
  input  logic                          advance,
  output logic [way_bits(NUM_WAYS)-1:0] victim
);
  localparam int unsigned WayBits = way_bits(NUM_WAYS);

  logic [WayBits-1:0] ptr [NUM_SETS];
  logic               found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SETS; i++) begin
        ptr[i] <= '0;
      end
    end else if (advance) begin
      ptr[set] <= (ptr[set] == WayBits'(NUM_WAYS - 1)) ? '0 : ptr[set] + 1'b1;
    end
  end

  always_comb begin
    victim = ptr[set];
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (!found && !valid_flags[i]) begin
        victim = WayBits'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate set-associative cache controller driving an external tag/data array.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned BLOCK_SIZE = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  cache_controller_if.slave                        cpu,
  output logic [way_bits(NUM_WAYS)-1:0]            way,
  output logic [set_bits(NUM_SETS)-1:0]            set,
  output logic [tag_bits(ADDR_SIZE, NUM_SETS)-1:0] tag,
  output logic                                     write_enable,
  output logic [BLOCK_SIZE-1:0]                    write_data,
  input  logic [BLOCK_SIZE-1:0]                    read_data,
  input  logic [NUM_WAYS-1:0]                      hits,
  input  logic [NUM_WAYS-1:0]                      valid_flags,
  output logic                                     mem_req_valid,
  input  logic                                     mem_req_ready,
  output logic                                     mem_req_write,
  output logic [ADDR_SIZE-1:0]                     mem_addr,
  output logic [31:0]                              mem_wdata,
  input  logic                                     mem_resp_valid,
  input  logic [31:0]                              mem_rdata,
  output logic [31:0]                              hit_count,
  output logic [31:0]                              miss_count
);
  localparam int unsigned SetBits = set_bits(NUM_SETS);
  localparam int unsigned TagBits = tag_bits(ADDR_SIZE, NUM_SETS);
  localparam int unsigned WayBits = way_bits(NUM_WAYS);

  state_t               state, state_next;
  logic                 write_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [WayBits-1:0]   victim_q, victim, hit_way;
  logic                 hit, advance;

  assign set           = addr_q[2 +: SetBits];
  assign tag           = addr_q[ADDR_SIZE-1 -: TagBits];
  assign hit           = |hits;
  assign mem_addr      = addr_q;
  assign mem_req_write = write_q;
  assign mem_wdata     = wdata_q;
  assign cpu.resp_rdata = rdata_q;

  always_comb begin
    hit_way = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (hits[i]) hit_way = WayBits'(i);
    end
  end

  cache_replacement #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_replacement (
    .clk         (clk),
    .rst         (rst),
    .set         (set),
    .valid_flags (valid_flags),
    .advance     (advance),
    .victim      (victim)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    cpu.req_ready  = 1'b0;
    cpu.resp_valid = 1'b0;
    mem_req_valid  = 1'b0;
    write_enable   = 1'b0;
    write_data     = wdata_q;
    way            = victim_q;
    advance        = 1'b0;
    unique case (state)
      IDLE: begin
        cpu.req_ready = 1'b1;
        if (cpu.req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        way = hit_way;
        if (write_q) begin
          write_enable = hit;
          state_next   = MEM_REQ;
        end else begin
          state_next = hit ? RESP : MEM_REQ;
        end
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) state_next = write_q ? RESP : FILL;
      end
      FILL: begin
        write_enable = 1'b1;
        write_data   = rdata_q;
        advance      = 1'b1;
        state_next   = RESP;
      end
      RESP: begin
        cpu.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rdata_q doubles as the fill buffer: it holds mem_rdata through FILL and is the response word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      victim_q   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu.req_valid) begin
            write_q <= cpu.req_write;
            addr_q  <= cpu.req_addr;
            wdata_q <= cpu.req_wdata;
          end
        end
        LOOKUP: begin
          victim_q <= victim;
          if (hit) hit_count <= sat_inc(hit_count);
          else     miss_count <= sat_inc(miss_count);
          if (write_q)  rdata_q <= '0;
          else if (hit) rdata_q <= read_data;
        end
        MEM_WAIT: begin
          if (mem_resp_valid && !write_q) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed plus randomized bench: behavioural cache model and backing memory predict every response.
module tb_cache_controller;
  localparam int NUM_SETS = 4;
  localparam int NUM_WAYS = 2;

  logic        clk;
  logic        rst;
  logic [0:0]  way;
  logic [1:0]  set;
  logic [27:0] tag;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [1:0]  hits;
  logic [1:0]  valid_flags;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count, miss_count;

  cache_controller_if #(.ADDR_SIZE(32)) cpu ();

  cache_controller #(
    .ADDR_SIZE  (32),
    .NUM_SETS   (NUM_SETS),
    .NUM_WAYS   (NUM_WAYS),
    .BLOCK_SIZE (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu            (cpu),
    .way            (way),
    .set            (set),
    .tag            (tag),
    .write_enable   (write_enable),
    .write_data     (write_data),
    .read_data      (read_data),
    .hits           (hits),
    .valid_flags    (valid_flags),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external cache_memory array.
  logic        arr_valid [NUM_SETS][NUM_WAYS] = '{default: '0};
  logic [27:0] arr_tag   [NUM_SETS][NUM_WAYS] = '{default: '0};
  logic [31:0] arr_data  [NUM_SETS][NUM_WAYS] = '{default: '0};

  always_comb begin
    hits        = '0;
    valid_flags = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hits[w]        = arr_valid[set][w] && (arr_tag[set][w] == tag);
      valid_flags[w] = arr_valid[set][w];
    end
  end
  assign read_data = arr_data[set][way];

  always @(posedge clk) begin
    if (write_enable) begin
      arr_valid[set][way] <= 1'b1;
      arr_tag[set][way]   <= tag;
      arr_data[set][way]  <= write_data;
    end
  end

  // Reference model: what the cache should hold, plus the backing store.
  bit          m_valid [NUM_SETS][NUM_WAYS];
  logic [27:0] m_tag   [NUM_SETS][NUM_WAYS];
  logic [31:0] m_data  [NUM_SETS][NUM_WAYS];
  int          m_ptr   [NUM_SETS];
  int unsigned m_hits, m_miss;
  logic [31:0] mem_store [logic [31:0]];

  int total, bad;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int rdy_dly, input bit noise, output int fill_way);
    int s, hw, v, we_cnt, mreq_cnt, rdy_cnt, rsp_cnt;
    logic [27:0] t;
    bit hit, exp_mem, exp_we, in_req, hs_pending, rsp_pending, done;
    logic [31:0] exp_rd, exp_we_data;
    int exp_we_way;

    s  = int'(addr[3:2]);
    t  = addr[31:4];
    hw = -1;
    for (int w = 0; w < NUM_WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    hit     = (hw >= 0);
    exp_mem = wr || !hit;
    exp_we  = wr ? hit : !hit;
    if (!mem_store.exists(addr)) mem_store[addr] = $urandom;
    if (hit) m_hits++; else m_miss++;
    exp_rd = '0; exp_we_way = 0; exp_we_data = '0;
    if (wr) begin
      mem_store[addr] = wdata;
      if (hit) begin
        exp_we_way = hw; exp_we_data = wdata; m_data[s][hw] = wdata;
      end
    end else if (hit) begin
      exp_rd = m_data[s][hw];
    end else begin
      v = m_ptr[s];
      for (int w = NUM_WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      exp_rd = mem_store[addr]; exp_we_way = v; exp_we_data = exp_rd;
      m_valid[s][v] = 1'b1; m_tag[s][v] = t; m_data[s][v] = exp_rd;
      m_ptr[s] = (m_ptr[s] + 1) % NUM_WAYS;
    end

    @(negedge clk);
    chk("idle_ready", cpu.req_ready, 1);
    cpu.req_valid = 1'b1; cpu.req_write = wr; cpu.req_addr = addr; cpu.req_wdata = wdata;
    @(posedge clk);
    we_cnt = 0; mreq_cnt = 0; rdy_cnt = 0; rsp_cnt = 0; fill_way = -1;
    in_req = 0; hs_pending = 0; rsp_pending = 0; done = 0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      cpu.req_valid  = noise && ($urandom_range(0, 1) == 1);
      cpu.req_write  = 1'($urandom);
      cpu.req_addr   = $urandom;
      cpu.req_wdata  = $urandom;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (noise && cyc == 1) begin
        mem_resp_valid = 1'b1; mem_rdata = $urandom;
      end
      if (hs_pending) begin
        chk("mreq_drop", mem_req_valid, 0);
        hs_pending = 0; in_req = 0; rsp_pending = 1; rsp_cnt = $urandom_range(0, 2);
      end else if (in_req) begin
        chk("mreq_hold", mem_req_valid, 1);
      end
      if (mem_req_valid) begin
        if (!in_req) begin in_req = 1; mreq_cnt++; rdy_cnt = 0; end
        chk("mem_addr", mem_addr, addr);
        chk("mem_write", mem_req_write, wr);
        if (wr) chk("mem_wdata", mem_wdata, wdata);
        if (rdy_cnt >= rdy_dly) begin mem_req_ready = 1'b1; hs_pending = 1; end
        else rdy_cnt++;
      end
      if (rsp_pending) begin
        if (rsp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = wr ? 32'h0BAD_F00D : mem_store[addr];
          rsp_pending = 0;
        end else rsp_cnt--;
      end
      if (write_enable) begin
        we_cnt++;
        fill_way = int'(way);
        chk("we_way", way, exp_we_way);
        chk("we_data", write_data, exp_we_data);
        chk("we_set", set, s);
        chk("we_tag", tag, t);
        if (wr) chk("we_in_lookup", cyc, 1);
      end
      if (cpu.resp_valid) begin
        done = 1;
        chk("resp_rdata", cpu.resp_rdata, exp_rd);
        if (!wr && hit) chk("hit_latency", cyc, 2);
        cpu.req_valid = 1'b0;
      end
    end
    chk("resp_seen", done, 1);
    chk("mem_req_count", mreq_cnt, exp_mem);
    chk("array_writes", we_cnt, exp_we);
    @(negedge clk);
    chk("resp_one_cycle", cpu.resp_valid, 0);
    chk("ready_again", cpu.req_ready, 1);
    chk("we_idle", write_enable, 0);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
  endtask

  task automatic reset_mid_wait(input logic [31:0] addr);
    bit seen;
    seen = 0;
    @(negedge clk);
    cpu.req_valid = 1'b1; cpu.req_write = 1'b0; cpu.req_addr = addr;
    @(negedge clk);
    cpu.req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_req_valid) begin seen = 1; mem_req_ready = 1'b1; end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    chk("rst_reached_wait", seen, 1);
    chk("rst_pre_miss", miss_count, m_miss + 1);
    rst = 1'b0;
    #1;
    chk("rst_resp_valid", cpu.resp_valid, 0);
    chk("rst_mem_req", mem_req_valid, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_ready", cpu.req_ready, 1);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_rdata", cpu.resp_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    m_hits = 0; m_miss = 0;
    for (int i = 0; i < NUM_SETS; i++) m_ptr[i] = 0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      chk("stray_resp", cpu.resp_valid, 0);
      chk("stray_we", write_enable, 0);
      chk("stray_mreq", mem_req_valid, 0);
      chk("stray_ready", cpu.req_ready, 1);
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    int fw;
    logic [31:0] a;
    total = 0; bad = 0; m_hits = 0; m_miss = 0;
    for (int s = 0; s < NUM_SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = '0; m_data[s][w] = '0;
      end
    end
    mem_store[32'h0000_0040] = 32'hDEAD_BEEF;
    rst = 1'b0;
    cpu.req_valid = 1'b0; cpu.req_write = 1'b0; cpu.req_addr = '0; cpu.req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", cpu.req_ready, 1);
    chk("reset_resp_valid", cpu.resp_valid, 0);
    chk("reset_mem_req", mem_req_valid, 0);
    chk("reset_we", write_enable, 0);
    chk("reset_rdata", cpu.resp_rdata, 0);
    chk("reset_hits", hit_count, 0);
    chk("reset_miss", miss_count, 0);
    rst = 1'b1;

    txn(1'b0, 32'h0000_0040, '0, 0, 0, fw);
    chk("cold_fill_way", fw, 0);
    chk("cold_miss_count", miss_count, 1);
    txn(1'b0, 32'h0000_0040, '0, 0, 0, fw);
    chk("rehit_count", hit_count, 1);
    txn(1'b0, 32'h0000_0140, '0, 1, 0, fw);
    chk("rr_fill_way1", fw, 1);
    txn(1'b0, 32'h0000_0240, '0, 0, 0, fw);
    chk("rr_wrap_way0", fw, 0);
    txn(1'b0, 32'h0000_0040, '0, 2, 0, fw);
    chk("evicted_refill", fw, 1);
    txn(1'b0, 32'h0000_0140, '0, 0, 0, fw);
    txn(1'b1, 32'h0000_0140, 32'h1234_5678, 5, 1, fw);
    txn(1'b0, 32'h0000_0140, '0, 0, 1, fw);
    chk("write_hit_readback", cpu.resp_rdata, 32'h1234_5678);
    txn(1'b1, 32'h0000_0340, 32'hCAFE_0001, 3, 1, fw);
    txn(1'b0, 32'h0000_0340, '0, 0, 0, fw);

    reset_mid_wait(32'h0000_1000);

    for (int i = 0; i < 40; i++) begin
      a = {24'h0, 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'b00};
      txn(1'($urandom), a, $urandom, $urandom_range(0, 3), 1'($urandom), fw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
